// File: rtl/qiak_master.sv
// Processor-side QBUS interrupt-acknowledge master: synchronises the bus inputs, resolves
// the pending interrupt level and runs the DIN/IAKO/RPLY handshake that fetches the vector.
module qiak_master #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETUP_CYC   = 6,
  parameter int unsigned TIMEOUT_CYC = 400
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        RINIT,
  input  logic [7:4]  RIRQ,
  input  logic        RRPLY,
  input  logic [15:0] RDAL,
  input  logic        bus_idle,
  output logic        TDIN,
  output logic        TIAKO,
  input  logic [2:0]  cpu_priority,
  output logic        int_pending,
  output logic [2:0]  int_level,
  input  logic        iak_start,
  output logic        iak_busy,
  output logic        vector_valid,
  output logic [8:0]  vector,
  output logic [2:0]  ack_level,
  output logic        iak_timeout
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIN,
    S_IAK,
    S_LATCH,
    S_RELEASE,
    S_ABORT
  } state_e;

  logic [SYNC_STAGES-1:0]      init_sync_q, init_sync_d;
  logic [SYNC_STAGES-1:0]      rply_sync_q, rply_sync_d;
  logic [SYNC_STAGES-1:0][3:0] irq_sync_q, irq_sync_d;
  logic [SYNC_STAGES-1:0][6:0] dal_sync_q, dal_sync_d;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    int_level_q, int_level_d;
  logic          int_pending_q, int_pending_d;
  logic          tdin_q, tdin_d;
  logic          tiako_q, tiako_d;
  logic          busy_q, busy_d;
  logic          vector_valid_q, vector_valid_d;
  logic          iak_timeout_q, iak_timeout_d;
  logic [8:0]    vector_q, vector_d;
  logic [2:0]    ack_level_q, ack_level_d;

  logic       init_s;
  logic       rply_s;
  logic [3:0] irq_s;
  logic [6:0] dal_s;

  // Only RDAL<8:2> carry vector bits; the rest of the bus is deliberately ignored.
  logic unused_dal;
  assign unused_dal = ^{RDAL[15:9], RDAL[1:0]};

  assign init_s = init_sync_q[SYNC_STAGES-1];
  assign rply_s = rply_sync_q[SYNC_STAGES-1];
  assign irq_s  = irq_sync_q[SYNC_STAGES-1];
  assign dal_s  = dal_sync_q[SYNC_STAGES-1];

  always_comb begin
    init_sync_d[0] = RINIT;
    rply_sync_d[0] = RRPLY;
    irq_sync_d[0]  = RIRQ;
    dal_sync_d[0]  = RDAL[8:2];
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      init_sync_d[i] = init_sync_q[i-1];
      rply_sync_d[i] = rply_sync_q[i-1];
      irq_sync_d[i]  = irq_sync_q[i-1];
      dal_sync_d[i]  = dal_sync_q[i-1];
    end
  end

  always_comb begin
    if (irq_s[3])      int_level_d = 3'd7;
    else if (irq_s[2]) int_level_d = 3'd6;
    else if (irq_s[1]) int_level_d = 3'd5;
    else if (irq_s[0]) int_level_d = 3'd4;
    else               int_level_d = 3'd0;
    int_pending_d = (int_level_d != 3'd0) && (int_level_d > cpu_priority);
  end

  always_comb begin
    state_d        = state_q;
    vector_d       = vector_q;
    ack_level_d    = ack_level_q;
    vector_valid_d = 1'b0;
    iak_timeout_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (iak_start && int_pending_q && bus_idle) begin
          state_d     = S_DIN;
          ack_level_d = int_level_q;
        end
      end
      S_DIN: begin
        if (timer_q == TW'(SETUP_CYC - 1)) state_d = S_IAK;
      end
      S_IAK: begin
        if (rply_s) begin
          state_d        = S_LATCH;
          vector_d       = {dal_s, 2'b00};
          vector_valid_d = 1'b1;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d       = S_ABORT;
          iak_timeout_d = 1'b1;
        end
      end
      S_LATCH: state_d = S_RELEASE;
      S_RELEASE: begin
        if (!rply_s) begin
          state_d = S_IDLE;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d       = S_ABORT;
          iak_timeout_d = 1'b1;
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q || state_q == S_IDLE) timer_d = '0;
    else                                         timer_d = timer_q + 1'b1;

    // Drive strobes from the next state so TIAKO is only ever high while in IAK.
    tdin_d  = (state_d == S_DIN) || (state_d == S_IAK);
    tiako_d = (state_d == S_IAK);
    busy_d  = (state_d != S_IDLE);

    if (init_s) begin
      state_d        = S_IDLE;
      timer_d        = '0;
      vector_d       = '0;
      ack_level_d    = '0;
      vector_valid_d = 1'b0;
      iak_timeout_d  = 1'b0;
      tdin_d         = 1'b0;
      tiako_d        = 1'b0;
      busy_d         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      init_sync_q    <= '0;
      rply_sync_q    <= '0;
      irq_sync_q     <= '0;
      dal_sync_q     <= '0;
      state_q        <= S_IDLE;
      timer_q        <= '0;
      int_level_q    <= '0;
      int_pending_q  <= 1'b0;
      tdin_q         <= 1'b0;
      tiako_q        <= 1'b0;
      busy_q         <= 1'b0;
      vector_valid_q <= 1'b0;
      iak_timeout_q  <= 1'b0;
      vector_q       <= '0;
      ack_level_q    <= '0;
    end else begin
      init_sync_q    <= init_sync_d;
      rply_sync_q    <= rply_sync_d;
      irq_sync_q     <= irq_sync_d;
      dal_sync_q     <= dal_sync_d;
      state_q        <= state_d;
      timer_q        <= timer_d;
      int_level_q    <= int_level_d;
      int_pending_q  <= int_pending_d;
      tdin_q         <= tdin_d;
      tiako_q        <= tiako_d;
      busy_q         <= busy_d;
      vector_valid_q <= vector_valid_d;
      iak_timeout_q  <= iak_timeout_d;
      vector_q       <= vector_d;
      ack_level_q    <= ack_level_d;
    end
  end

  assign TDIN         = tdin_q;
  assign TIAKO        = tiako_q;
  assign int_pending  = int_pending_q;
  assign int_level    = int_level_q;
  assign iak_busy     = busy_q;
  assign vector_valid = vector_valid_q;
  assign vector       = vector_q;
  assign ack_level    = ack_level_q;
  assign iak_timeout  = iak_timeout_q;

endmodule

// File: tb/tb_qiak_master.sv
// Directed bench for qiak_master: stimulus pushes expected vector/timeout events into a
// scoreboard queue that an independent monitor drains whenever the DUT pulses an outcome.
module tb_qiak_master;

  localparam int SYNC_STAGES = 2;
  localparam int SETUP_CYC   = 6;
  localparam int TIMEOUT_CYC = 400;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        RINIT;
  logic [7:4]  RIRQ;
  logic        RRPLY;
  logic [15:0] RDAL;
  logic        bus_idle;
  logic        TDIN;
  logic        TIAKO;
  logic [2:0]  cpu_priority;
  logic        int_pending;
  logic [2:0]  int_level;
  logic        iak_start;
  logic        iak_busy;
  logic        vector_valid;
  logic [8:0]  vector;
  logic [2:0]  ack_level;
  logic        iak_timeout;

  qiak_master #(
    .SYNC_STAGES(SYNC_STAGES),
    .SETUP_CYC  (SETUP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .RINIT       (RINIT),
    .RIRQ        (RIRQ),
    .RRPLY       (RRPLY),
    .RDAL        (RDAL),
    .bus_idle    (bus_idle),
    .TDIN        (TDIN),
    .TIAKO       (TIAKO),
    .cpu_priority(cpu_priority),
    .int_pending (int_pending),
    .int_level   (int_level),
    .iak_start   (iak_start),
    .iak_busy    (iak_busy),
    .vector_valid(vector_valid),
    .vector      (vector),
    .ack_level   (ack_level),
    .iak_timeout (iak_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_vec;
    logic [8:0] vec;
    logic [2:0] lvl;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every outcome pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (TIAKO) check("tiako_needs_tdin", TDIN, 1);
      if (vector_valid || iak_timeout) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {vector_valid, iak_timeout}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("event_kind", {vector_valid, iak_timeout}, e.is_vec ? 2'b10 : 2'b01);
          if (e.is_vec) begin
            check("vector", vector, e.vec);
            check("ack_level", ack_level, e.lvl);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic [3:0] irq;
    logic [2:0] pri;
    logic [2:0] lvl;
    logic       pend;
  } prio_t;

  prio_t prio_tab[6] = '{
    '{4'b0000, 3'd0, 3'd0, 1'b0},
    '{4'b1000, 3'd6, 3'd7, 1'b1},
    '{4'b1000, 3'd7, 3'd7, 1'b0},
    '{4'b0011, 3'd3, 3'd5, 1'b1},
    '{4'b0001, 3'd4, 3'd4, 1'b0},
    '{4'b0001, 3'd3, 3'd4, 1'b1}
  };

  initial begin
    int n;
    int n2;
    reset_n = 1'b0; RINIT = 1'b0; RIRQ = '0; RRPLY = 1'b0; RDAL = '0;
    bus_idle = 1'b1; cpu_priority = '0; iak_start = 1'b0;
    repeat (3) tick();
    check("rst_tdin", TDIN, 0);
    check("rst_tiako", TIAKO, 0);
    check("rst_busy", iak_busy, 0);
    check("rst_vector", vector, 0);
    check("rst_ack_level", ack_level, 0);
    check("rst_int_level", int_level, 0);
    reset_n = 1'b1;
    tick();

    // 1: IRQ5 over priority 4, device answers 0o000264
    cpu_priority = 3'd4; RIRQ = 4'b0010;
    repeat (3) tick();
    check("t1_int_level", int_level, 5);
    check("t1_int_pending", int_pending, 1);
    sb.push_back('{1'b1, 9'o264, 3'd5});
    iak_start = 1'b1;
    tick();
    iak_start = 1'b0;
    check("t1_tdin_din", TDIN, 1);
    check("t1_busy", iak_busy, 1);
    check("t1_ack_level", ack_level, 5);
    n = 1;
    while (!TIAKO && n < 40) begin tick(); n++; end
    check("t1_start_to_tiako", n, SETUP_CYC + 1);
    RDAL = 16'o000264; RRPLY = 1'b1;
    n = 0;
    while (!vector_valid && n < 20) begin tick(); n++; end
    check("t1_rply_to_valid", n, SYNC_STAGES + 1);
    tick();
    check("t1_tdin_released", TDIN, 0);
    check("t1_tiako_released", TIAKO, 0);
    RRPLY = 1'b0; RDAL = '0;
    n = 0;
    while (iak_busy && n < 20) begin tick(); n++; end
    check("t1_back_idle", iak_busy, 0);

    // 2: IRQ4+IRQ6 against priorities 5 and 6
    cpu_priority = 3'd5; RIRQ = 4'b0101;
    repeat (3) tick();
    check("t2_int_level", int_level, 6);
    check("t2_pending_p5", int_pending, 1);
    cpu_priority = 3'd6;
    tick();
    check("t2_pending_p6", int_pending, 0);
    iak_start = 1'b1;
    tick();
    iak_start = 1'b0;
    repeat (3) tick();
    check("t2_ignored_tdin", TDIN, 0);
    check("t2_ignored_busy", iak_busy, 0);

    foreach (prio_tab[i]) begin
      RIRQ = prio_tab[i].irq; cpu_priority = prio_tab[i].pri;
      repeat (3) tick();
      check("prio_level", int_level, prio_tab[i].lvl);
      check("prio_pending", int_pending, prio_tab[i].pend);
    end

    // 3: no reply, IRQ dropped after start; IAKO held then abort
    RIRQ = 4'b1000; cpu_priority = 3'd0;
    repeat (3) tick();
    sb.push_back('{1'b0, 9'd0, 3'd0});
    iak_start = 1'b1;
    tick();
    iak_start = 1'b0; RIRQ = '0;
    n = 1;
    while (!TIAKO && n < 40) begin tick(); n++; end
    check("t3_start_to_tiako", n, SETUP_CYC + 1);
    n2 = 0;
    while (TIAKO && n2 < TIMEOUT_CYC + 50) begin tick(); n2++; end
    check("t3_tiako_hold", n2, TIMEOUT_CYC);
    check("t3_timeout_pulse", iak_timeout, 1);
    tick();
    check("t3_timeout_one_clk", iak_timeout, 0);
    check("t3_idle", iak_busy, 0);

    // 4: RPLY high before the cycle and stuck after latch
    RIRQ = 4'b1000; RDAL = 16'o177774; RRPLY = 1'b1;
    repeat (3) tick();
    sb.push_back('{1'b1, 9'o774, 3'd7});
    sb.push_back('{1'b0, 9'd0, 3'd0});
    iak_start = 1'b1;
    tick();
    iak_start = 1'b0;
    n = 1;
    while (!vector_valid && n < 40) begin tick(); n++; end
    check("t4_early_rply_latency", n, SETUP_CYC + 2);
    tick();
    check("t4_tiako_released", TIAKO, 0);
    n2 = 1;
    while (!iak_timeout && n2 < TIMEOUT_CYC + 50) begin tick(); n2++; end
    check("t4_release_timeout", n2, TIMEOUT_CYC + 1);
    tick();
    check("t4_idle", iak_busy, 0);
    RRPLY = 1'b0; RDAL = '0;
    repeat (3) tick();

    // 5a: reset during IAK
    iak_start = 1'b1;
    tick();
    iak_start = 1'b0;
    n = 1;
    while (!TIAKO && n < 40) begin tick(); n++; end
    check("t5_tiako_up", TIAKO, 1);
    reset_n = 1'b0;
    tick();
    check("t5_rst_tdin", TDIN, 0);
    check("t5_rst_tiako", TIAKO, 0);
    check("t5_rst_busy", iak_busy, 0);
    check("t5_rst_ack", ack_level, 0);
    reset_n = 1'b1;
    repeat (4) tick();

    // 5b: bus INIT during IAK
    iak_start = 1'b1;
    tick();
    iak_start = 1'b0;
    n = 1;
    while (!TIAKO && n < 40) begin tick(); n++; end
    check("t5_init_tiako_up", TIAKO, 1);
    RINIT = 1'b1;
    n = 0;
    while (TIAKO && n < 10) begin tick(); n++; end
    check("t5_init_latency", n, SYNC_STAGES + 1);
    check("t5_init_tdin", TDIN, 0);
    check("t5_init_busy", iak_busy, 0);
    check("t5_init_ack", ack_level, 0);
    RINIT = 1'b0;
    repeat (4) tick();

    // 6: start without bus ownership, then a duplicate start mid-cycle
    bus_idle = 1'b0;
    iak_start = 1'b1;
    tick();
    iak_start = 1'b0;
    repeat (2) tick();
    check("t6_no_bus_tdin", TDIN, 0);
    check("t6_no_bus_busy", iak_busy, 0);
    bus_idle = 1'b1;
    sb.push_back('{1'b1, 9'o100, 3'd7});
    iak_start = 1'b1;
    tick();
    iak_start = 1'b0;
    repeat (2) tick();
    RIRQ = 4'b0010;
    iak_start = 1'b1;
    tick();
    iak_start = 1'b0;
    check("t6_dup_busy", iak_busy, 1);
    check("t6_dup_ack", ack_level, 7);
    n = 0;
    while (!TIAKO && n < 40) begin tick(); n++; end
    RDAL = 16'o000100; RRPLY = 1'b1;
    n = 0;
    while (!vector_valid && n < 20) begin tick(); n++; end
    check("t6_valid_seen", vector_valid, 1);
    RRPLY = 1'b0; RDAL = '0;
    n = 0;
    while (iak_busy && n < 20) begin tick(); n++; end
    repeat (10) tick();
    check("t6_single_cycle_tdin", TDIN, 0);
    check("t6_single_cycle_busy", iak_busy, 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
